// File: rtl/fsm_phase_tracker.sv
// Receive-side phase tracker for the cyclic 0,1,0 controller bit stream.
// Recovers controller phase, reports the recovered state once locked and counts violations.
module fsm_phase_tracker #(
  parameter logic [1:0] S0        = 2'd0,
  parameter logic [1:0] S1        = 2'd1,
  parameter logic [1:0] S2        = 2'd2,
  parameter int         LOCK_CNT  = 2,
  parameter int         ERR_LIMIT = 3,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_in,
  output logic [1:0]       state_est,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MISS_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
  localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(ERR_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // Unknown phase encodings fall back to S0 so the flywheel always recovers.
  function automatic logic [1:0] f_advance(input logic [1:0] ph);
    logic [1:0] nxt;
    if (ph == S0)      nxt = S1;
    else if (ph == S1) nxt = S2;
    else if (ph == S2) nxt = S0;
    else               nxt = S0;
    return nxt;
  endfunction

  logic [1:0]        r_state;
  logic [1:0]        r_phase;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [MISS_W-1:0] r_miss_cnt;
  logic [1:0]        r_state_est;
  logic              r_locked;
  logic              r_err;
  logic [CNT_W-1:0]  r_err_count;

  logic              w_match;
  logic [1:0]        w_sample_ph;
  logic [GOOD_W-1:0] w_good_inc;
  logic [MISS_W-1:0] w_miss_inc;
  logic [1:0]        w_state_n;
  logic [1:0]        w_phase_n;
  logic [GOOD_W-1:0] w_good_n;
  logic [MISS_W-1:0] w_miss_n;
  logic              w_err_n;
  logic [CNT_W-1:0]  w_err_count_n;

  assign w_match     = (state_in == (r_phase == S1));
  assign w_good_inc  = r_good_cnt + GOOD_W'(1'b1);
  assign w_miss_inc  = r_miss_cnt + MISS_W'(1'b1);
  // An anchoring 1 in HUNT is by definition the S1 sample.
  assign w_sample_ph = (r_state == ST_HUNT) ? S1 : r_phase;

  // Next-state and counter update logic for the tracker FSM.
  always_comb begin
    w_state_n     = r_state;
    w_phase_n     = r_phase;
    w_good_n      = r_good_cnt;
    w_miss_n      = r_miss_cnt;
    w_err_n       = 1'b0;
    w_err_count_n = r_err_count;
    case (r_state)
      ST_HUNT: begin
        if (state_in) begin
          w_phase_n = S2;
          w_good_n  = GOOD_W'(1'b1);
          w_state_n = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
        end else begin
          w_state_n = ST_HUNT;
        end
      end
      ST_VERIFY: begin
        if (w_match) begin
          w_phase_n = f_advance(r_phase);
          if (r_phase == S1) begin
            w_good_n  = w_good_inc;
            w_state_n = (w_good_inc == GOOD_TGT) ? ST_LOCKED : ST_VERIFY;
          end else begin
            w_state_n = ST_VERIFY;
          end
        end else if (state_in) begin
          w_phase_n = S2;
          w_good_n  = GOOD_W'(1'b1);
        end else begin
          w_state_n = ST_HUNT;
          w_phase_n = S0;
          w_good_n  = '0;
        end
      end
      ST_LOCKED: begin
        w_phase_n = f_advance(r_phase);
        if (w_match) begin
          w_miss_n = '0;
        end else begin
          w_err_n       = 1'b1;
          w_err_count_n = (r_err_count == CNT_MAX) ? CNT_MAX : r_err_count + CNT_W'(1'b1);
          if (w_miss_inc == MISS_TGT) begin
            w_state_n = ST_HUNT;
            w_miss_n  = '0;
            w_good_n  = '0;
          end else begin
            w_miss_n  = w_miss_inc;
          end
        end
      end
      default: begin
        w_state_n = ST_HUNT;
        w_phase_n = S0;
        w_good_n  = '0;
        w_miss_n  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_phase     <= S0;
      r_good_cnt  <= '0;
      r_miss_cnt  <= '0;
      r_state_est <= S0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_n;
      r_phase     <= w_phase_n;
      r_good_cnt  <= w_good_n;
      r_miss_cnt  <= w_miss_n;
      r_state_est <= (w_state_n == ST_LOCKED) ? w_sample_ph : S0;
      r_locked    <= (w_state_n == ST_LOCKED);
      r_err       <= w_err_n;
      r_err_count <= w_err_count_n;
    end
  end

  assign state_est = r_state_est;
  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_fsm_phase_tracker.sv
// Directed bench for fsm_phase_tracker: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_fsm_phase_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       state_in;
  logic [1:0] est1, est2;
  logic       lk1, lk2, er1, er2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int checks = 0;
  int failures = 0;

  fsm_phase_tracker u_dut (
    .clk(clk), .reset(reset), .state_in(state_in),
    .state_est(est1), .locked(lk1), .err(er1), .err_count(cnt1)
  );

  fsm_phase_tracker #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .state_in(state_in),
    .state_est(est2), .locked(lk2), .err(er2), .err_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic send(input logic b);
    state_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; state_in = 1'b0;
    #2;
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", lk1); end
    checks++; if (est1 !== 2'd0) begin failures++; $display("FAIL reset_est got=%0d exp=0", est1); end
    checks++; if (er1 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", er1); end
    checks++; if (cnt1 !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    logic [1:0] exp_est [3] = '{2'd2, 2'd0, 2'd1};
    logic       bits [3] = '{1'b0, 1'b0, 1'b1};
    send(1'b0);
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL lock_hunt got=%b exp=0", lk1); end
    send(1'b1);
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL lock_anchor got=%b exp=0", lk1); end
    send(1'b0); send(1'b0);
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", lk1); end
    send(1'b1);
    checks++; if (lk1 !== 1'b1) begin failures++; $display("FAIL lock_edge got=%b exp=1", lk1); end
    checks++; if (est1 !== 2'd1) begin failures++; $display("FAIL lock_est got=%0d exp=1", est1); end
    for (int i = 0; i < 3; i++) begin
      send(bits[i]);
      checks++; if (est1 !== exp_est[i]) begin failures++; $display("FAIL lock_cycle[%0d] est got=%0d exp=%0d", i, est1, exp_est[i]); end
      checks++; if (er1 !== 1'b0 || lk1 !== 1'b1) begin failures++; $display("FAIL lock_cycle[%0d] err/locked got=%b/%b exp=0/1", i, er1, lk1); end
    end
  endtask

  task automatic test_single_flip();
    send(1'b0); send(1'b0);
    send(1'b0);
    checks++; if (er1 !== 1'b1) begin failures++; $display("FAIL flip_err got=%b exp=1", er1); end
    checks++; if (cnt1 !== 8'd1) begin failures++; $display("FAIL flip_cnt got=%0d exp=1", cnt1); end
    checks++; if (lk1 !== 1'b1) begin failures++; $display("FAIL flip_locked got=%b exp=1", lk1); end
    checks++; if (est1 !== 2'd1) begin failures++; $display("FAIL flip_est got=%0d exp=1", est1); end
    send(1'b0);
    checks++; if (er1 !== 1'b0) begin failures++; $display("FAIL flip_err_once got=%b exp=0", er1); end
    checks++; if (est1 !== 2'd2) begin failures++; $display("FAIL flip_est_next got=%0d exp=2", est1); end
    send(1'b0); send(1'b1);
    checks++; if (est1 !== 2'd1 || lk1 !== 1'b1) begin failures++; $display("FAIL flip_resync est/locked got=%0d/%b exp=1/1", est1, lk1); end
  endtask

  task automatic test_reset_midlock();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL midrst_locked got=%b exp=0", lk1); end
    checks++; if (est1 !== 2'd0) begin failures++; $display("FAIL midrst_est got=%0d exp=0", est1); end
    checks++; if (cnt1 !== 8'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", cnt1); end
    @(posedge clk); #1;
    reset = 1'b0;
    send(1'b0);
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL midrst_hunt got=%b exp=0", lk1); end
    send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    checks++; if (lk1 !== 1'b1 || est1 !== 2'd1) begin failures++; $display("FAIL midrst_relock locked/est got=%b/%0d exp=1/1", lk1, est1); end
  endtask

  task automatic test_unlock();
    logic       bits [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp_est [3] = '{2'd2, 2'd0, 2'd0};
    logic       exp_lk [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send(bits[i]);
      checks++; if (er1 !== 1'b1) begin failures++; $display("FAIL unlock_err[%0d] got=%b exp=1", i, er1); end
      checks++; if (cnt1 !== 8'(i + 1)) begin failures++; $display("FAIL unlock_cnt[%0d] got=%0d exp=%0d", i, cnt1, i + 1); end
      checks++; if (lk1 !== exp_lk[i] || est1 !== exp_est[i]) begin failures++; $display("FAIL unlock_state[%0d] locked/est got=%b/%0d exp=%b/%0d", i, lk1, est1, exp_lk[i], exp_est[i]); end
    end
    send(1'b0);
    checks++; if (er1 !== 1'b0 || lk1 !== 1'b0) begin failures++; $display("FAIL unlock_after err/locked got=%b/%b exp=0/0", er1, lk1); end
    send(1'b0); send(1'b1); send(1'b0); send(1'b0);
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL unlock_verify got=%b exp=0", lk1); end
    send(1'b1);
    checks++; if (lk1 !== 1'b1 || est1 !== 2'd1 || cnt1 !== 8'd3) begin failures++; $display("FAIL unlock_relock locked/est/cnt got=%b/%0d/%0d exp=1/1/3", lk1, est1, cnt1); end
  endtask

  task automatic test_const_ones();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      send(1'b1);
      checks++; if (lk1 !== 1'b0 || er1 !== 1'b0 || cnt1 !== 8'd0 || est1 !== 2'd0) begin
        failures++; $display("FAIL ones[%0d] locked/err/cnt/est got=%b/%b/%0d/%0d exp=0/0/0/0", i, lk1, er1, cnt1, est1);
      end
    end
  endtask

  task automatic test_cnt_saturation();
    logic [1:0] exp2;
    pulse_reset();
    send(1'b0); send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    checks++; if (lk2 !== 1'b1) begin failures++; $display("FAIL sat_lock got=%b exp=1", lk2); end
    for (int i = 0; i < 5; i++) begin
      exp2 = (i >= 2) ? 2'd3 : 2'(i + 1);
      send(1'b0); send(1'b0); send(1'b0);
      checks++; if (er2 !== 1'b1) begin failures++; $display("FAIL sat_err[%0d] got=%b exp=1", i, er2); end
      checks++; if (cnt2 !== exp2) begin failures++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", i, cnt2, exp2); end
      checks++; if (cnt1 !== 8'(i + 1)) begin failures++; $display("FAIL sat_cnt8[%0d] got=%0d exp=%0d", i, cnt1, i + 1); end
      checks++; if (lk2 !== 1'b1) begin failures++; $display("FAIL sat_locked[%0d] got=%b exp=1", i, lk2); end
    end
    send(1'b0);
    checks++; if (er2 !== 1'b0 || lk2 !== 1'b1 || cnt2 !== 2'd3) begin failures++; $display("FAIL sat_end err/locked/cnt got=%b/%b/%0d exp=0/1/3", er2, lk2, cnt2); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_reset_midlock();
    test_unlock();
    test_const_ones();
    test_cnt_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_phase_tracker.md
# fsm_phase_tracker

Receive-side tracker for the 1-bit `state_out` stream produced by the three-state cyclic controller (S0→S1→S2→S0, output bit = state bit 0, giving the repeating pattern 0,1,0). It sits on the consumer side of that link, in the same clock domain. It recovers the controller's phase from the bit stream, reports the recovered 2-bit state once locked, and counts pattern violations.

## Interface
- `S0`, default 0: encoding of state S0 (2-bit).
- `S1`, default 1: encoding of state S1.
- `S2`, default 2: encoding of state S2. S0/S1/S2 must be distinct.
- `LOCK_CNT`, default 2: number of consecutive correctly predicted S1 markers (1-bits) needed to enter LOCKED. Must be ≥1.
- `ERR_LIMIT`, default 3: number of consecutive mismatches in LOCKED that drops lock. Must be ≥1.
- `CNT_W`, default 8: width of the error counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `state_in` input 1: serial bit from the controller's `state_out`, synchronous to `clk`.
- `state_est` output 2: recovered state of the bit sampled at the last edge. S0 when not locked.
- `locked` output 1: high while in LOCKED.
- `err` output 1: one-cycle pulse for each mismatch detected while LOCKED.
- `err_count` output CNT_W: saturating count of `err` pulses.

## Operation
- Tracker FSM has three states: HUNT, VERIFY, LOCKED. Internal registers: `phase` (predicted state of the next sample), `good_cnt`, `miss_cnt`.
- Expected bit for a sample is 1 iff `phase == S1`. Phase advance is S0→S1→S2→S0; any other value of `phase` advances to S0.
- HUNT:
  - `state_in=1` anchors: `phase<=S2`, `good_cnt<=1`. Go to VERIFY, or straight to LOCKED if LOCK_CNT==1.
  - `state_in=0`: stay in HUNT.
- VERIFY:
  - Match: advance `phase`. If the matched sample was S1, increment `good_cnt`; on reaching LOCK_CNT go to LOCKED.
  - Mismatch with `state_in=1`: re-anchor in VERIFY (`phase<=S2`, `good_cnt<=1`).
  - Mismatch with `state_in=0`: go to HUNT.
  - No `err` pulse is ever produced in VERIFY.
- LOCKED:
  - `phase` always advances (flywheel), whether the sample matched or not.
  - Match: `miss_cnt<=0`.
  - Mismatch: `err` pulses, `err_count` increments (saturating at 2^CNT_W−1), `miss_cnt` increments. When `miss_cnt` reaches ERR_LIMIT, go to HUNT with `locked<=0` and `state_est<=S0` on that same edge.
- `state_est` updates on each edge to the phase of the sample just taken, while the next FSM state is LOCKED. Otherwise it is S0.
- `err_count` is cleared only by `reset`.

## Timing
- All outputs are registered and update on the same rising edge that samples `state_in`. There is no additional latency.
- Lock edge: the edge sampling the LOCK_CNT-th correct 1. After that edge, `locked=1` and `state_est=S1`.
- With a clean stream and LOCK_CNT=2, `locked` rises 3 cycles after the first anchoring 1 is sampled.
- `err` is high for exactly the cycle following each LOCKED mismatch edge. It is never high two cycles for one event.
- Unlock edge: the edge sampling the ERR_LIMIT-th consecutive mismatch. `err` pulses on that edge as well.
- `reset` asserted at any time, including mid-lock, immediately forces: state HUNT, `phase=S0`, `good_cnt=0`, `miss_cnt=0`, `state_est=S0`, `locked=0`, `err=0`, `err_count=0`.
- After `reset` deasserts, the first edge samples normally.

## Test plan
- Reset mid-lock: assert `reset` asynchronously between edges while locked → all outputs 0 (state_est=S0) before the next edge. After release, the tracker re-hunts.
- Clean stream 0,1,0,0,1,0,… with defaults → first 1 at edge k: VERIFY. `locked=1`, `state_est=S1` after edge k+3. Then state_est cycles S2,S0,S1 with no `err` pulses.
- Single flipped bit while locked (a 0 sent where S1 is expected) → one `err` pulse, `err_count=1`, `locked` stays 1, `state_est` continues S1,S2,S0 without slipping.
- Three consecutive corrupted bits while locked (defaults) → three `err` pulses, `err_count=3`. `locked=0` and `state_est=S0` after the third edge, then a fresh lock on the clean stream.
- Constant `state_in=1` from reset → re-anchor every cycle in VERIFY, never locked, `err=0`, `err_count=0`.
- CNT_W=2, five isolated single-bit errors while locked → `err_count` reads 1,2,3,3,3 and `locked` stays 1 throughout.
